// File: rtl/zscale_top.sv
// RV32I tile: a multicycle FETCH/EXEC/LOAD core with a boot ROM at 0x0000_0000
// and a byte-writable data RAM at 0x8000_0000. Other addresses read as 0.

module zscale_sram #(
   parameter int WORDS = 2048,
   parameter int AW = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] ram [WORDS-1:0];

   always_ff @(posedge clk) begin
      rdata <= ram[addr];
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end
endmodule

module zscale_mem #(
   parameter int CAPACITY = 8192,
   parameter int AW = $clog2(CAPACITY / 4)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   zscale_sram #(.WORDS(CAPACITY / 4), .AW(AW)) ram (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );
endmodule

module zscale_top #(
   parameter int BOOT_CAPACITY = 8192,
   parameter int DRAM_CAPACITY = 65536
) (
   input  logic clk,
   input  logic reset,
   input  logic io_prci_reset,
   input  logic io_prci_id,
   input  logic io_prci_interrupts_mtip,
   input  logic io_prci_interrupts_msip,
   input  logic io_prci_interrupts_meip,
   input  logic io_prci_interrupts_seip,
   input  logic io_prci_interrupts_debug
);
   localparam int BOOT_AW = $clog2(BOOT_CAPACITY / 4);
   localparam int DRAM_AW = $clog2(DRAM_CAPACITY / 4);
   localparam logic [31:0] DRAM_BASE = 32'h8000_0000;
   localparam logic [31:0] BOOT_SIZE = 32'(BOOT_CAPACITY);
   localparam logic [31:0] DRAM_SIZE = 32'(DRAM_CAPACITY);

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6f;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, LOAD = 2'd2} state_t;

   logic        core_rst;
   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] regs [31:0];
   logic [31:0] ir;
   logic [1:0]  ld_lo;
   logic        rsel_boot, rsel_dram;
   logic [31:0] boot_rdata, dram_rdata, rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we, boot_hit, dram_hit;
   logic        rd_we;
   logic [31:0] rd_wdata;
   logic        unused_prci;

   assign core_rst = reset | io_prci_reset;
   assign unused_prci = ^{io_prci_id, io_prci_interrupts_mtip, io_prci_interrupts_msip,
                          io_prci_interrupts_meip, io_prci_interrupts_seip,
                          io_prci_interrupts_debug};

   // Memories read every cycle; rsel_* remembers which one the last address hit.
   assign boot_hit = (mem_addr < BOOT_SIZE);
   assign dram_hit = ((mem_addr - DRAM_BASE) < DRAM_SIZE);
   assign rdata    = rsel_boot ? boot_rdata : (rsel_dram ? dram_rdata : 32'h0);

   zscale_mem #(.CAPACITY(BOOT_CAPACITY), .AW(BOOT_AW)) bootmem (
      .clk   (clk),
      .we    (1'b0),
      .be    (mem_be),
      .addr  (mem_addr[BOOT_AW+1:2]),
      .wdata (mem_wdata),
      .rdata (boot_rdata)
   );

   zscale_mem #(.CAPACITY(DRAM_CAPACITY), .AW(DRAM_AW)) dram (
      .clk   (clk),
      .we    (mem_we & dram_hit & ~core_rst),
      .be    (mem_be),
      .addr  (mem_addr[DRAM_AW+1:2]),
      .wdata (mem_wdata),
      .rdata (dram_rdata)
   );

   always_ff @(posedge clk) begin
      rsel_boot <= boot_hit;
      rsel_dram <= dram_hit;
   end

   // The fetched word is only valid during EXEC; LOAD uses the latched copy.
   logic [31:0] inst;
   assign inst = (state == EXEC) ? rdata : ir;

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1v, rs2v, op_b, alu, ld_val, ld_shift;
   logic [15:0] ld_half;
   logic [4:0]  shamt;
   logic        taken;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign f3     = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'h0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign rs1v   = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
   assign rs2v   = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
   assign op_b   = (opcode == OPC_OP) ? rs2v : imm_i;
   assign shamt  = op_b[4:0];

   always_comb begin
      alu = 32'h0;
      case (f3)
         3'd0: alu = (opcode == OPC_OP && inst[30]) ? rs1v - op_b : rs1v + op_b;
         3'd1: alu = rs1v << shamt;
         3'd2: alu = {31'h0, $signed(rs1v) < $signed(op_b)};
         3'd3: alu = {31'h0, rs1v < op_b};
         3'd4: alu = rs1v ^ op_b;
         3'd5: alu = inst[30] ? $unsigned($signed(rs1v) >>> shamt) : rs1v >> shamt;
         3'd6: alu = rs1v | op_b;
         default: alu = rs1v & op_b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'd0: taken = (rs1v == rs2v);
         3'd1: taken = (rs1v != rs2v);
         3'd4: taken = ($signed(rs1v) < $signed(rs2v));
         3'd5: taken = ($signed(rs1v) >= $signed(rs2v));
         3'd6: taken = (rs1v < rs2v);
         3'd7: taken = (rs1v >= rs2v);
         default: taken = 1'b0;
      endcase
   end

   assign ld_shift = rdata >> {ld_lo, 3'b000};
   assign ld_half  = ld_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      ld_val = rdata;
      case (f3)
         3'd0: ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1: ld_val = {{16{ld_half[15]}}, ld_half};
         3'd4: ld_val = {24'h0, ld_shift[7:0]};
         3'd5: ld_val = {16'h0, ld_half};
         default: ld_val = rdata;
      endcase
   end

   always_comb begin
      state_d   = state;
      pc_d      = pc;
      rd_we     = 1'b0;
      rd_wdata  = alu;
      mem_addr  = pc;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_wdata = rs2v;
      case (state)
         FETCH: state_d = EXEC;
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc + 32'd4;
            case (opcode)
               OPC_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
               OPC_AUIPC: begin rd_we = 1'b1; rd_wdata = pc + imm_u; end
               OPC_JAL: begin
                  rd_we    = 1'b1;
                  rd_wdata = pc + 32'd4;
                  pc_d     = pc + imm_j;
               end
               OPC_JALR: begin
                  rd_we    = 1'b1;
                  rd_wdata = pc + 32'd4;
                  pc_d     = (rs1v + imm_i) & ~32'd1;
               end
               OPC_BRANCH: if (taken) pc_d = pc + imm_b;
               OPC_OPIMM, OPC_OP: rd_we = 1'b1;
               OPC_LOAD: begin
                  mem_addr = rs1v + imm_i;
                  pc_d     = pc;
                  state_d  = LOAD;
               end
               OPC_STORE: begin
                  mem_addr = rs1v + imm_s;
                  mem_we   = 1'b1;
                  case (f3)
                     3'd0: begin
                        mem_wdata = {4{rs2v[7:0]}};
                        mem_be    = 4'b0001 << mem_addr[1:0];
                     end
                     3'd1: begin
                        mem_wdata = {2{rs2v[15:0]}};
                        mem_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                     end
                     3'd2: mem_be = 4'b1111;
                     default: mem_be = 4'b0000;
                  endcase
               end
               default: ;
            endcase
         end
         LOAD: begin
            state_d  = FETCH;
            pc_d     = pc + 32'd4;
            rd_we    = 1'b1;
            rd_wdata = ld_val;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge core_rst) begin
      if (core_rst) begin
         state <= FETCH;
         pc    <= 32'h0;
         ir    <= 32'h0;
         ld_lo <= 2'd0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         if (state == EXEC) begin
            ir    <= rdata;
            ld_lo <= mem_addr[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge core_rst) begin
      if (core_rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else if (rd_we && rd != 5'd0) begin
         regs[rd] <= rd_wdata;
      end
   end
endmodule

// File: tb/tb_zscale_top.sv
// Directed program tests for zscale_top: the bench assembles RV32I programs into
// bootmem, pushes expected results to exp_q and compares them against DRAM words.

module tb_zscale_top;
   localparam int TOHOST = 1024;
   localparam int OPC_LUI = 'h37, OPC_AUIPC = 'h17, OPC_JALR = 'h67;
   localparam int OPC_LOAD = 'h03, OPC_OPIMM = 'h13;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic io_prci_reset = 1'b0;
   logic [31:0] exp_q[$];
   int pass_cnt = 0;
   int check_cnt = 0;
   int asm_idx = 0;
   int slot = 0;
   int cycles;
   logic done;
   logic [31:0] first_word, p;

   int          r_f7[10]  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
   int          r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
   logic [31:0] r_exp[10] = '{32'h0000000F, 32'hFFFFFFC9, 32'hFFFFFF60, 32'h1, 32'h0,
                              32'hFFFFFFCF, 32'h1FFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFEF, 32'h20};
   int          i_f3[9]   = '{2, 3, 5, 5, 1, 4, 7, 6, 0};
   int          i_rs[9]   = '{1, 2, 1, 1, 2, 1, 1, 2, 1};
   int          i_imm[9]  = '{-21, -1, 'h402, 30, 4, -1, 'h7F, 'h400, 'h7FF};
   logic [31:0] i_exp[9]  = '{32'h0, 32'h1, 32'hFFFFFFFB, 32'h3, 32'h230, 32'h13,
                              32'h6C, 32'h423, 32'h7EB};
   int          br_f3[6]  = '{0, 1, 4, 5, 6, 7};
   int          ld_f3[8]  = '{0, 4, 0, 4, 1, 5, 1, 2};
   int          ld_off[8] = '{0, 0, 2, 3, 2, 3, 0, 3};
   logic [31:0] ld_exp[8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h00000080,
                              32'hFFFF80FF, 32'h000080FF, 32'h00000080, 32'h80FF0080};

   always #5 clk = ~clk;

   zscale_top dut (
      .clk                      (clk),
      .reset                    (reset),
      .io_prci_reset            (io_prci_reset),
      .io_prci_id               (1'b0),
      .io_prci_interrupts_mtip  (1'b0),
      .io_prci_interrupts_msip  (1'b0),
      .io_prci_interrupts_meip  (1'b0),
      .io_prci_interrupts_seip  (1'b0),
      .io_prci_interrupts_debug (1'b0)
   );

   function automatic logic [31:0] enc_i(input int op, input int f3, input int rd,
                                         input int rs1, input int imm);
      logic [31:0] im = imm;
      return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction

   function automatic logic [31:0] enc_s(input int f3, input int rs2, input int rs1, input int imm);
      logic [31:0] im = imm;
      return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
      logic [31:0] im = imm;
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input int op, input int rd, input int imm20);
      logic [31:0] im = imm20;
      return {im[19:0], 5'(rd), 7'(op)};
   endfunction

   function automatic logic [31:0] enc_j(input int rd, input int imm);
      logic [31:0] im = imm;
      return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd,
                                         input int rs1, input int rs2);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] pattern(input int i);
      return 32'(i) * 32'h9E37_79B1 + 32'h1234_5677;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
      check(tag, obs, exp);
   endtask

   task automatic emit(input logic [31:0] w);
      dut.bootmem.ram.ram[asm_idx] = w;
      asm_idx++;
   endtask

   task automatic emit_slot(input int rs, input logic [31:0] exp);
      emit(enc_s(2, rs, 5, slot * 4));
      exp_q.push_back(exp);
      slot++;
   endtask

   task automatic emit_tohost_store(input int val);
      emit(enc_i(OPC_OPIMM, 0, 1, 0, val));
      emit(enc_u(OPC_LUI, 2, 'h80001));
      emit(enc_s(2, 1, 2, 0));
      emit(enc_j(0, 0));
   endtask

   // Hold reset for two cycles, then wipe bootmem and fill dram with a known pattern.
   task automatic start_test();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2048; i++) dut.bootmem.ram.ram[i] = 32'h0;
      for (int i = 0; i < 16384; i++) dut.dram.ram.ram[i] = pattern(i);
      asm_idx = 0;
      slot = 0;
   endtask

   task automatic wait_tohost(input int limit, output int cyc, output logic ok);
      logic [31:0] pre;
      pre = dut.dram.ram.ram[TOHOST];
      ok = 1'b0;
      cyc = limit;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (dut.dram.ram.ram[TOHOST] !== pre) begin
            ok = 1'b1;
            cyc = c + 1;
            break;
         end
      end
   endtask

   task automatic run_prog(input int limit, output int cyc, output logic ok);
      reset = 1'b0;
      wait_tohost(limit, cyc, ok);
   endtask

   initial begin
      int n_bad;

      // Pass path: exact write timing and no collateral writes.
      start_test();
      emit_tohost_store(1);
      exp_q.push_back(32'h1);
      run_prog(20, cycles, done);
      check("t1_done", {31'h0, done}, 32'h1);
      check("t1_cycles", 32'(cycles), 32'd6);
      pop_check("t1_tohost", dut.dram.ram.ram[TOHOST]);
      n_bad = 0;
      for (int i = 0; i < 16384; i++)
         if (i != TOHOST && dut.dram.ram.ram[i] !== pattern(i)) n_bad++;
      check("t1_other_words", 32'(n_bad), 32'h0);

      // Reset state after a program has dirtied pc and x1.
      start_test();
      check("rst_pc", dut.pc, 32'h0);
      check("rst_state", 32'(dut.state), 32'h0);
      check("rst_x1", dut.regs[1], 32'h0);

      // Fail code 3.
      emit_tohost_store(7);
      exp_q.push_back(32'h7);
      run_prog(20, cycles, done);
      check("t2_done", {31'h0, done}, 32'h1);
      pop_check("t2_tohost", dut.dram.ram.ram[TOHOST]);
      check("t2_lsb", {31'h0, dut.dram.ram.ram[TOHOST][0]}, 32'h1);
      check("t2_code", dut.dram.ram.ram[TOHOST] >> 1, 32'h3);

      // Byte and halfword lanes.
      for (int t = 0; t < 2; t++) begin
         start_test();
         dut.dram.ram.ram[TOHOST] = 32'hAABBCCDD;
         emit(enc_i(OPC_OPIMM, 0, 1, 0, (t == 0) ? 'h11 : 'h566));
         emit(enc_u(OPC_LUI, 2, 'h80001));
         emit(enc_s(t, 1, 2, 2));
         emit(enc_j(0, 0));
         exp_q.push_back((t == 0) ? 32'hAA11CCDD : 32'h0566CCDD);
         run_prog(20, cycles, done);
         check($sformatf("t3_done%0d", t), {31'h0, done}, 32'h1);
         pop_check($sformatf("t3_lane%0d", t), dut.dram.ram.ram[TOHOST]);
      end

      // Load extension and lane selection; loads take three cycles.
      for (int t = 0; t < 8; t++) begin
         start_test();
         dut.dram.ram.ram[0] = 32'h80FF0080;
         dut.dram.ram.ram[TOHOST] = 32'hDEADBEEF;
         emit(enc_u(OPC_LUI, 2, 'h80000));
         emit(enc_i(OPC_LOAD, ld_f3[t], 3, 2, ld_off[t]));
         emit(enc_u(OPC_LUI, 4, 'h80001));
         emit(enc_s(2, 3, 4, 0));
         emit(enc_j(0, 0));
         exp_q.push_back(ld_exp[t]);
         run_prog(30, cycles, done);
         check($sformatf("t4_done%0d", t), {31'h0, done}, 32'h1);
         check($sformatf("t4_cycles%0d", t), 32'(cycles), 32'd9);
         pop_check($sformatf("t4_load%0d", t), dut.dram.ram.ram[TOHOST]);
      end

      // Countdown loop with a write to x0 inside the body.
      start_test();
      emit(enc_i(OPC_OPIMM, 0, 1, 0, 5));
      emit(enc_i(OPC_OPIMM, 0, 3, 0, 0));
      emit(enc_i(OPC_OPIMM, 0, 3, 3, 1));
      emit(enc_i(OPC_OPIMM, 0, 1, 1, -1));
      emit(enc_i(OPC_OPIMM, 0, 0, 0, 9));
      emit(enc_b(1, 1, 0, -12));
      emit(enc_i(OPC_OPIMM, 1, 4, 3, 1));
      emit(enc_i(OPC_OPIMM, 6, 4, 4, 1));
      emit(enc_r(0, 0, 4, 4, 0));
      emit(enc_u(OPC_LUI, 2, 'h80001));
      emit(enc_s(2, 4, 2, 0));
      emit(enc_j(0, 0));
      exp_q.push_back((32'd5 << 1) | 32'd1);
      run_prog(100, cycles, done);
      check("t5_done", {31'h0, done}, 32'h1);
      pop_check("t5_tohost", dut.dram.ram.ram[TOHOST]);
      check("t5_x0", dut.regs[0], 32'h0);

      // ALU, immediates, AUIPC, unmapped/boot loads, branches, jumps, NOP opcodes.
      start_test();
      first_word = enc_u(OPC_LUI, 5, 'h80000);
      emit(first_word);
      emit(enc_i(OPC_OPIMM, 0, 1, 0, -20));
      emit(enc_i(OPC_OPIMM, 0, 2, 0, 35));
      for (int k = 0; k < 10; k++) begin
         emit(enc_r(r_f7[k], r_f3[k], 3, 1, 2));
         emit_slot(3, r_exp[k]);
      end
      for (int k = 0; k < 9; k++) begin
         emit(enc_i(OPC_OPIMM, i_f3[k], 3, i_rs[k], i_imm[k]));
         emit_slot(3, i_exp[k]);
      end
      p = 32'(asm_idx * 4);
      emit(enc_u(OPC_AUIPC, 3, 'h12345));
      emit_slot(3, p + 32'h12345000);
      emit(enc_u(OPC_LUI, 10, 'h40000));
      emit(enc_i(OPC_LOAD, 2, 3, 10, 0));
      emit_slot(3, 32'h0);
      emit(enc_i(OPC_LOAD, 2, 3, 0, 0));
      emit_slot(3, first_word);
      emit(enc_u(OPC_LUI, 11, 'h1));
      emit(enc_s(2, 1, 11, 0));
      emit(enc_i(OPC_OPIMM, 0, 6, 0, 0));
      for (int k = 0; k < 6; k++) begin
         emit(enc_b(br_f3[k], 1, 2, 8));
         emit(enc_i(OPC_OPIMM, 6, 6, 6, 1 << k));
      end
      emit_slot(6, 32'h19);
      p = 32'(asm_idx * 4);
      emit(enc_j(7, 8));
      emit(enc_i(OPC_OPIMM, 0, 7, 0, 0));
      emit_slot(7, p + 32'd4);
      p = 32'(asm_idx * 4);
      emit(enc_u(OPC_AUIPC, 9, 0));
      emit(enc_i(OPC_JALR, 0, 8, 9, 13));
      emit(enc_i(OPC_OPIMM, 0, 8, 0, 0));
      emit_slot(8, p + 32'd8);
      emit(32'h0000000F);
      emit(32'h00000073);
      emit(32'hFFFFFFFF);
      emit_slot(31, 32'h0);
      emit_slot(1, 32'hFFFFFFEC);
      emit_tohost_store(1);
      exp_q.push_back(32'h1);
      run_prog(600, cycles, done);
      check("t6_done", {31'h0, done}, 32'h1);
      for (int k = 0; k < slot; k++)
         pop_check($sformatf("t6_slot%0d", k), dut.dram.ram.ram[k]);
      pop_check("t6_tohost", dut.dram.ram.ram[TOHOST]);
      check("t6_boot_ro", dut.bootmem.ram.ram[1024], 32'h0);

      // Core reset pulsed while the SW sits in EXEC.
      start_test();
      emit_tohost_store(5);
      exp_q.push_back(32'h5);
      reset = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (32'(dut.state) == 1 && dut.pc == 32'h8) begin
            done = 1'b1;
            break;
         end
      end
      check("t7_reached_sw", {31'h0, done}, 32'h1);
      io_prci_reset = 1'b1;
      @(negedge clk);
      check("t7_no_write", dut.dram.ram.ram[TOHOST], pattern(TOHOST));
      check("t7_pc", dut.pc, 32'h0);
      check("t7_x1", dut.regs[1], 32'h0);
      io_prci_reset = 1'b0;
      wait_tohost(30, cycles, done);
      check("t7_done", {31'h0, done}, 32'h1);
      check("t7_cycles", 32'(cycles), 32'd6);
      pop_check("t7_tohost", dut.dram.ram.ram[TOHOST]);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
